// File: rtl/raifes_hasti_sram.sv
// raifes_hasti_sram: AHB-lite (HASTI) single-port SRAM slave with byte lanes,
// configurable wait states, write-to-read forwarding and two-cycle ERROR response.
module raifes_hasti_sram #(
  parameter int ADDR_WIDTH  = 14,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic        hmastlock,
  input  logic [3:0]  hprot,
  input  logic [1:0]  htrans,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic        hresp
);

  localparam int         DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] offset);
    logic [3:0] mask;
    case (size)
      3'd0:    mask = 4'b0001 << offset;
      3'd1:    mask = offset[1] ? 4'b1100 : 4'b0011;
      3'd2:    mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  function automatic logic is_legal(input logic [2:0] size, input logic [1:0] offset);
    logic ok;
    case (size)
      3'd0:    ok = 1'b1;
      3'd1:    ok = ~offset[0];
      3'd2:    ok = (offset == 2'd0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  mask);
    logic [31:0] word;
    for (int b = 0; b < 4; b++) begin
      word[8*b +: 8] = mask[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return word;
  endfunction

  logic [31:0]           mem_r [DEPTH];
  state_t                state_r;
  state_t                state_next_s;
  logic [3:0]            wait_cnt_r;
  logic [3:0]            wait_cnt_next_s;
  logic [ADDR_WIDTH-1:0] idx_r;
  logic [1:0]            offset_r;
  logic [2:0]            size_r;
  logic                  write_r;
  logic                  hready_r;
  logic                  hresp_r;
  logic [31:0]           hrdata_r;
  logic                  accept_s;
  logic                  legal_s;
  logic [ADDR_WIDTH-1:0] haddr_idx_s;
  logic                  commit_s;
  logic [3:0]            commit_mask_s;
  logic                  rd_load_s;
  logic [ADDR_WIDTH-1:0] rd_idx_s;
  logic [31:0]           rd_word_s;
  logic                  unused_s;

  assign accept_s      = hready_r & hsel & htrans[1];
  assign haddr_idx_s   = haddr[ADDR_WIDTH+1:2];
  assign legal_s       = is_legal(hsize, haddr[1:0]);
  assign commit_s      = (state_r == S_DATA) & write_r;
  assign commit_mask_s = lane_mask(size_r, offset_r);
  assign unused_s      = ^{hburst, hmastlock, hprot, htrans[0], haddr[31:ADDR_WIDTH+2]};

  assign hrdata = hrdata_r;
  assign hready = hready_r;
  assign hresp  = hresp_r;

  // Next-state and wait-counter logic
  always_comb begin
    state_next_s    = state_r;
    wait_cnt_next_s = wait_cnt_r;
    case (state_r)
      S_WAIT: begin
        wait_cnt_next_s = wait_cnt_r - 4'd1;
        if (wait_cnt_r <= 4'd1) begin
          state_next_s = S_DATA;
        end else begin
          state_next_s = S_WAIT;
        end
      end
      S_ERR1: state_next_s = S_ERR2;
      S_IDLE, S_DATA, S_ERR2: begin
        if (!accept_s) begin
          state_next_s = S_IDLE;
        end else if (!legal_s) begin
          state_next_s = S_ERR1;
        end else if (WS_LOAD == 4'd0) begin
          state_next_s = S_DATA;
        end else begin
          state_next_s    = S_WAIT;
          wait_cnt_next_s = WS_LOAD;
        end
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // Read word for the data phase about to start; merges a same-edge write to that word
  always_comb begin
    rd_idx_s  = (state_r == S_WAIT) ? idx_r : haddr_idx_s;
    rd_load_s = (state_next_s == S_DATA) && !((state_r == S_WAIT) ? write_r : hwrite);
    if (commit_s && (idx_r == rd_idx_s)) begin
      rd_word_s = merge_lanes(mem_r[rd_idx_s], hwdata, commit_mask_s);
    end else begin
      rd_word_s = mem_r[rd_idx_s];
    end
  end

  // Control state, address-phase capture and registered bus outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      wait_cnt_r <= 4'd0;
      idx_r      <= {ADDR_WIDTH{1'b0}};
      offset_r   <= 2'd0;
      size_r     <= 3'd0;
      write_r    <= 1'b0;
      hready_r   <= 1'b1;
      hresp_r    <= 1'b0;
      hrdata_r   <= 32'd0;
    end else begin
      state_r    <= state_next_s;
      wait_cnt_r <= wait_cnt_next_s;
      if (accept_s) begin
        idx_r    <= haddr_idx_s;
        offset_r <= haddr[1:0];
        size_r   <= hsize;
        write_r  <= hwrite;
      end
      hready_r <= (state_next_s == S_IDLE) || (state_next_s == S_DATA) ||
                  (state_next_s == S_ERR2);
      hresp_r  <= (state_next_s == S_ERR1) || (state_next_s == S_ERR2);
      if (rd_load_s) begin
        hrdata_r <= rd_word_s;
      end
    end
  end

  // Byte-lane write port; commits on the edge that ends a write's DATA cycle
  always_ff @(posedge clk) begin
    if (commit_s) begin
      for (int b = 0; b < 4; b++) begin
        if (commit_mask_s[b]) begin
          mem_r[idx_r][8*b +: 8] <= hwdata[8*b +: 8];
        end
      end
    end
  end

endmodule
